// File: rtl/shift_reg_rx_if.sv
// Three-wire 74HC595-style link as seen by the receiver, plus the
// reconstructed frame outputs that the checker side consumes.
interface shift_reg_rx_if #(
    parameter int DATA_W = 24
);
    logic                        st_cp;
    logic                        sh_cp;
    logic                        d;
    logic [DATA_W-1:0]           data;
    logic                        d_valid;
    logic                        frame_err;
    logic [$clog2(DATA_W+2)-1:0] bit_cnt;
    logic [15:0]                 frame_cnt;

    modport master (
        output st_cp, sh_cp, d,
        input  data, d_valid, frame_err, bit_cnt, frame_cnt
    );

    modport slave (
        input  st_cp, sh_cp, d,
        output data, d_valid, frame_err, bit_cnt, frame_cnt
    );
endinterface

// File: rtl/shift_reg_rx.sv
// Serial-to-parallel receiver for a 595-style chain: oversamples st_cp/sh_cp/d
// in the clk domain, rebuilds each latched frame and flags bad bit counts.
module shift_reg_rx #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1
) (
    input  logic           clk,
    input  logic           rst,
    shift_reg_rx_if.slave  rx
);
    localparam int BCW = $clog2(DATA_W + 2);
    localparam int ACW = $clog2(SYNC_STAGES + 2);
    localparam logic [BCW-1:0] FULL_CNT = BCW'(DATA_W);
    localparam logic [BCW-1:0] SAT_CNT  = BCW'(DATA_W + 1);
    localparam logic [ACW-1:0] ARM_DONE = ACW'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] st_sync_p0;
    logic [SYNC_STAGES-1:0] sh_sync_p0;
    logic [SYNC_STAGES-1:0] d_sync_p0;
    logic                   st_hist_p1;
    logic                   sh_hist_p1;
    logic [ACW-1:0]         arm_cnt;

    logic [DATA_W-1:0]      sreg_p1;
    logic [BCW-1:0]         bit_cnt_p1;
    logic [DATA_W-1:0]      data_p2;
    logic                   vld_p2;
    logic                   frame_err_p2;
    logic [15:0]            frame_cnt_p2;

    logic                   st_s;
    logic                   sh_s;
    logic                   d_s;
    logic                   armed;
    logic                   st_rise;
    logic                   sh_rise;
    logic [DATA_W-1:0]      sreg_next;
    logic [BCW-1:0]         bit_cnt_next;

    // ---- stage p0 -> p1: synchronized levels and edge detection
    always_comb begin
        st_s    = st_sync_p0[SYNC_STAGES-1];
        sh_s    = sh_sync_p0[SYNC_STAGES-1];
        d_s     = d_sync_p0[SYNC_STAGES-1];
        armed   = (arm_cnt == ARM_DONE);
        st_rise = armed & st_s & ~st_hist_p1;
        sh_rise = armed & sh_s & ~sh_hist_p1;
    end

    // ---- stage p1: shift register and bit count, shift applied before latch
    always_comb begin
        sreg_next    = sreg_p1;
        bit_cnt_next = bit_cnt_p1;
        if (sh_rise) begin
            if (MSB_FIRST != 0) begin
                sreg_next = {sreg_p1[DATA_W-2:0], d_s};
            end else begin
                sreg_next = {d_s, sreg_p1[DATA_W-1:1]};
            end
            if (bit_cnt_p1 != SAT_CNT) begin
                bit_cnt_next = bit_cnt_p1 + 1'b1;
            end
        end
    end

    // ---- stage p2: frame latch
    always_ff @(posedge clk) begin
        if (rst) begin
            st_sync_p0   <= '0;
            sh_sync_p0   <= '0;
            d_sync_p0    <= '0;
            st_hist_p1   <= 1'b0;
            sh_hist_p1   <= 1'b0;
            arm_cnt      <= '0;
            sreg_p1      <= '0;
            bit_cnt_p1   <= '0;
            data_p2      <= '0;
            vld_p2       <= 1'b0;
            frame_err_p2 <= 1'b0;
            frame_cnt_p2 <= '0;
        end else begin
            st_sync_p0 <= {st_sync_p0[SYNC_STAGES-2:0], rx.st_cp};
            sh_sync_p0 <= {sh_sync_p0[SYNC_STAGES-2:0], rx.sh_cp};
            d_sync_p0  <= {d_sync_p0[SYNC_STAGES-2:0], rx.d};
            // History always follows sync, so a wire high at reset release
            // has settled into hist by the time edges are armed.
            st_hist_p1 <= st_s;
            sh_hist_p1 <= sh_s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            sreg_p1 <= sreg_next;
            vld_p2  <= st_rise;
            if (st_rise) begin
                data_p2      <= sreg_next;
                frame_err_p2 <= (bit_cnt_next != FULL_CNT);
                bit_cnt_p1   <= '0;
                frame_cnt_p2 <= frame_cnt_p2 + 16'd1;
            end else begin
                bit_cnt_p1 <= bit_cnt_next;
            end
        end
    end

    assign rx.data      = data_p2;
    assign rx.d_valid   = vld_p2;
    assign rx.frame_err = frame_err_p2;
    assign rx.bit_cnt   = bit_cnt_p1;
    assign rx.frame_cnt = frame_cnt_p2;
endmodule

// File: tb/tb_shift_reg_rx.sv
// Directed bench for shift_reg_rx: one MSB-first and one LSB-first receiver
// share the same three wires.
module tb_shift_reg_rx;
    logic clk = 1'b0;
    logic rst;
    logic st_cp;
    logic sh_cp;
    logic d;
    int   checks = 0;
    int   errors = 0;
    int   vcnt   = 0;

    always #5 clk = ~clk;

    shift_reg_rx_if #(.DATA_W(24)) bus_m ();
    shift_reg_rx_if #(.DATA_W(24)) bus_l ();

    assign bus_m.st_cp = st_cp;
    assign bus_m.sh_cp = sh_cp;
    assign bus_m.d     = d;
    assign bus_l.st_cp = st_cp;
    assign bus_l.sh_cp = sh_cp;
    assign bus_l.d     = d;

    shift_reg_rx #(.DATA_W(24), .SYNC_STAGES(2), .MSB_FIRST(1)) dut_m (
        .clk(clk), .rst(rst), .rx(bus_m)
    );
    shift_reg_rx #(.DATA_W(24), .SYNC_STAGES(2), .MSB_FIRST(0)) dut_l (
        .clk(clk), .rst(rst), .rx(bus_l)
    );

    always @(negedge clk) begin
        if (bus_m.d_valid === 1'b1) vcnt <= vcnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic shift_bit(input logic b);
        d = b;
        repeat (3) @(negedge clk);
        sh_cp = 1'b1;
        repeat (3) @(negedge clk);
        sh_cp = 1'b0;
    endtask

    task automatic shift_word(input logic [23:0] w, input int n, input bit msb);
        for (int i = 0; i < n; i++) begin
            if (i < 24) shift_bit(msb ? w[23-i] : w[i]);
            else        shift_bit(1'b0);
        end
    endtask

    // st_cp pulse (optionally with a coincident sh_cp rise); lat is the number
    // of negedges from the pin rise to the first observed d_valid.
    task automatic latch(input bit coinc, input logic b, output int lat);
        lat = -1;
        if (coinc) d = b;
        repeat (3) @(negedge clk);
        st_cp = 1'b1;
        if (coinc) sh_cp = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus_m.d_valid === 1'b1 && lat < 0) lat = i;
            if (i == 3) begin
                st_cp = 1'b0;
                sh_cp = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; st_cp = 1'b0; sh_cp = 1'b0; d = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus_m.data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 000000", bus_m.data); end
        checks++; if (bus_m.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b expected 0", bus_m.d_valid); end
        checks++; if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus_m.frame_err); end
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d expected 0", bus_m.bit_cnt); end
        checks++; if (bus_m.frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", bus_m.frame_cnt); end
    endtask

    task automatic test_arming();
        int v0;
        rst = 1'b1; st_cp = 1'b1; sh_cp = 1'b1;
        repeat (4) @(negedge clk);
        v0  = vcnt;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL arming_d_valid: got %0d pulses expected 0", vcnt - v0); end
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL arming_bit_cnt: got %0d expected 0", bus_m.bit_cnt); end
        checks++; if (bus_m.frame_cnt !== 16'd0) begin errors++; $display("FAIL arming_frame_cnt: got %0d expected 0", bus_m.frame_cnt); end
        st_cp = 1'b0; sh_cp = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL falling_bit_cnt: got %0d expected 0", bus_m.bit_cnt); end
        checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL falling_d_valid: got %0d pulses expected 0", vcnt - v0); end
    endtask

    task automatic test_nominal();
        int v0;
        int lat;
        v0 = vcnt;
        shift_word(24'hA5C30F, 24, 1'b1);
        latch(1'b0, 1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL nominal_latency: got %0d expected 3", lat); end
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL nominal_pulses: got %0d expected 1", vcnt - v0); end
        checks++; if (bus_m.data !== 24'hA5C30F) begin errors++; $display("FAIL nominal_data: got %h expected a5c30f", bus_m.data); end
        checks++; if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL nominal_frame_err: got %b expected 0", bus_m.frame_err); end
        checks++; if (bus_m.frame_cnt !== 16'd1) begin errors++; $display("FAIL nominal_frame_cnt: got %0d expected 1", bus_m.frame_cnt); end
    endtask

    task automatic test_short_long();
        int lat;
        shift_word(24'h3C3C3C, 23, 1'b1);
        checks++; if (bus_m.bit_cnt !== 5'd23) begin errors++; $display("FAIL short_bit_cnt: got %0d expected 23", bus_m.bit_cnt); end
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.frame_err !== 1'b1) begin errors++; $display("FAIL short_frame_err: got %b expected 1", bus_m.frame_err); end
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL short_bit_cnt_clr: got %0d expected 0", bus_m.bit_cnt); end
        shift_word(24'hFFFFFF, 30, 1'b1);
        checks++; if (bus_m.bit_cnt !== 5'd25) begin errors++; $display("FAIL long_bit_cnt: got %0d expected 25", bus_m.bit_cnt); end
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.frame_err !== 1'b1) begin errors++; $display("FAIL long_frame_err: got %b expected 1", bus_m.frame_err); end
        shift_word(24'h5A5A5A, 24, 1'b1);
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL good_frame_err: got %b expected 0", bus_m.frame_err); end
        checks++; if (bus_m.data !== 24'h5A5A5A) begin errors++; $display("FAIL good_data: got %h expected 5a5a5a", bus_m.data); end
        checks++; if (bus_m.frame_cnt !== 16'd4) begin errors++; $display("FAIL good_frame_cnt: got %0d expected 4", bus_m.frame_cnt); end
    endtask

    task automatic test_coincident();
        int lat;
        shift_word(24'h000001, 23, 1'b1);
        latch(1'b1, 1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL coinc_latency: got %0d expected 3", lat); end
        checks++; if (bus_m.data !== 24'h000001) begin errors++; $display("FAIL coinc_data: got %h expected 000001", bus_m.data); end
        checks++; if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL coinc_frame_err: got %b expected 0", bus_m.frame_err); end
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL coinc_bit_cnt: got %0d expected 0", bus_m.bit_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        int lat;
        shift_word(24'hFFFFFF, 12, 1'b1);
        v0  = vcnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus_m.bit_cnt !== 5'd0) begin errors++; $display("FAIL midrst_bit_cnt: got %0d expected 0", bus_m.bit_cnt); end
        checks++; if (bus_m.frame_cnt !== 16'd0) begin errors++; $display("FAIL midrst_frame_cnt: got %0d expected 0", bus_m.frame_cnt); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        shift_word(24'h123456, 24, 1'b1);
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.data !== 24'h123456) begin errors++; $display("FAIL midrst_data: got %h expected 123456", bus_m.data); end
        checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL midrst_pulses: got %0d expected 1", vcnt - v0); end
        checks++; if (bus_m.frame_cnt !== 16'd1) begin errors++; $display("FAIL midrst_frame_cnt_after: got %0d expected 1", bus_m.frame_cnt); end
        checks++; if (bus_m.frame_err !== 1'b0) begin errors++; $display("FAIL midrst_frame_err: got %b expected 0", bus_m.frame_err); end
    endtask

    task automatic test_order();
        int lat;
        shift_word(24'hA5C30F, 24, 1'b0);
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_l.data !== 24'hA5C30F) begin errors++; $display("FAIL lsb_data: got %h expected a5c30f", bus_l.data); end
        checks++; if (bus_l.frame_err !== 1'b0) begin errors++; $display("FAIL lsb_frame_err: got %b expected 0", bus_l.frame_err); end
        checks++; if (bus_m.data !== 24'hF0C3A5) begin errors++; $display("FAIL msb_reversed_data: got %h expected f0c3a5", bus_m.data); end
    endtask

    task automatic test_wrap();
        int lat;
        @(negedge clk);
        force dut_m.frame_cnt_p2 = 16'hFFFE;
        @(negedge clk);
        release dut_m.frame_cnt_p2;
        @(negedge clk);
        checks++; if (bus_m.frame_cnt !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h expected fffe", bus_m.frame_cnt); end
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h expected ffff", bus_m.frame_cnt); end
        latch(1'b0, 1'b0, lat);
        checks++; if (bus_m.frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", bus_m.frame_cnt); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL wrap_latency: got %0d expected 3", lat); end
    endtask

    initial begin
        test_reset();
        test_arming();
        test_nominal();
        test_short_long();
        test_coincident();
        test_reset_mid_frame();
        test_order();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_reg_rx.md
Name: shift_reg_rx

Overview:
- Serial-to-parallel receiver for the three-wire 74HC595-style interface: st_cp (storage clock), sh_cp (shift clock) and d (data).
- Oversamples all three wires in the clk_1M domain and reconstructs each latched frame as a parallel word.
- Flags malformed frames and keeps a count of received frames.
- Used as the loopback and checker end of the display link, and as a synthesizable stand-in for the external register chain.

Parameters:
- DATA_W, 24: frame width in bits, equal to the chained register width.
- SYNC_STAGES, 2: synchronizer depth on each input wire; must be >= 2.
- MSB_FIRST, 1: 1 means the first bit shifted ends up in data[DATA_W-1]; 0 means it ends up in data[0].

Ports:
- clk  in  1  system clock (the clk_1M domain).
- rst  in  1  synchronous, active-high reset.
- st_cp  in  1  storage clock from the transmitter; asynchronous to clk.
- sh_cp  in  1  shift clock from the transmitter; asynchronous to clk.
- d  in  1  serial data; asynchronous to clk.
- data  out  DATA_W  last latched frame.
- d_valid  out  1  one-cycle pulse when data updates.
- frame_err  out  1  sticky per frame; valid with d_valid, held until the next latch.
- bit_cnt  out  $clog2(DATA_W+2)  shift edges seen since the last latch.
- frame_cnt  out  16  number of latched frames; wraps.

Behaviour:
- Reset is synchronous, active-high and overrides everything:
  - data=0, d_valid=0, frame_err=0, bit_cnt=0, frame_cnt=0.
  - Internal shift register = 0; all synchronizer flops = 0; arm counter = 0.
- Synchronization:
  - Each wire passes through SYNC_STAGES flops.
  - An edge-history flop holds the previous synchronized value.
  - A rising edge is (sync==1 && hist==0).
- Arming after reset:
  - Edge detection is disabled until SYNC_STAGES+1 cycles after rst deasserts.
  - While disarmed, hist tracks sync every cycle.
  - Effect: a wire already high at reset release is never treated as an edge.
- Shift on sh_cp rising edge (armed):
  - MSB_FIRST=1: sreg <= {sreg[DATA_W-2:0], d_s}.
  - MSB_FIRST=0: sreg <= {d_s, sreg[DATA_W-1:1]}.
  - d_s is d's synchronized value in the same cycle the edge is detected; d passes through an identical pipeline, so it aligns with sh_cp.
  - bit_cnt increments and saturates at DATA_W+1, which marks an overrun.
- Latch on st_cp rising edge (armed):
  - data <= sreg, taken after any same-cycle shift.
  - d_valid=1 for exactly one cycle.
  - frame_err <= (bit_cnt_next != DATA_W).
  - bit_cnt <= 0.
  - frame_cnt <= frame_cnt+1, wrapping 16'hFFFF -> 0.
  - sreg is NOT cleared, matching the 595.
- Simultaneous sh_cp and st_cp rising in the same cycle:
  - The shift applies first, and that bit counts toward the frame.
  - The latched word includes the new bit.
  - bit_cnt then resets to 0.
- Latency: d_valid rises SYNC_STAGES+1 clk cycles after the st_cp pin rises.
- Input timing requirement: each level on st_cp/sh_cp must be stable for >= SYNC_STAGES+1 clk cycles, and d must be stable one cycle before and after the sh_cp rising edge. Violations are not detected. The team's transmitter satisfies this by construction.
- Falling edges have no effect.
- No edges means no activity; outputs hold indefinitely.
- Back-to-back frames: a latch followed immediately by shift edges of the next frame needs no idle gap.
- Reset mid-frame: the partial frame is discarded, no d_valid is produced, and arming restarts.

Test Plan:
- Arming: hold sh_cp=1 and st_cp=1 through reset release, then idle 10 cycles -> d_valid never asserts; bit_cnt=0; frame_cnt=0.
- Nominal frame, MSB_FIRST=1: shift 24'hA5C30F MSB first, then pulse st_cp -> one d_valid pulse exactly SYNC_STAGES+1=3 cycles after the st_cp pin rises; data=24'hA5C30F; frame_err=0; frame_cnt=1.
- Short and long frames: 23 shifts then latch -> frame_err=1, bit_cnt was 23. Then 30 shifts then latch -> frame_err=1, bit_cnt saturated at 25. Then a correct 24-bit frame -> frame_err=0.
- Coincident edges: 23 shifts, then the 24th sh_cp and st_cp rise on the same clk -> frame_err=0; data includes the final bit (check with pattern 24'h000001).
- Reset mid-frame: reset after 12 shifts, then send a full frame 24'h123456 -> data=24'h123456; exactly one d_valid; frame_cnt=1.
- Wrap and order: preload via 65536 frames (or force) -> frame_cnt wraps to 0. With MSB_FIRST=0, send 24'hA5C30F LSB first -> data=24'hA5C30F.
